// File: rtl/dst_track_pipe.sv
// Destination-register tracking pipeline with stall/flush and hazard hits.
// Pairs lddw low/high slots into one 64-bit write to the low slot's dst.
module dst_track_pipe #(
  parameter int REG_W = 4,
  parameter int DEPTH = 2,
  parameter int IMM_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [REG_W-1:0]   in_dst,
  input  logic               in_lddw,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic               stall,
  input  logic               flush,
  input  logic [REG_W-1:0]   src_idx,
  output logic [DEPTH-1:0]   hit_vec,
  output logic               out_valid,
  output logic [REG_W-1:0]   out_dst,
  output logic               lddw_pending,
  output logic               lddw_done,
  output logic [REG_W-1:0]   lddw_dst,
  output logic [2*IMM_W-1:0] lddw_imm
);

  typedef enum logic {
    IDLE,
    WAIT_HI
  } st_t;

  st_t st_q, st_d;

  logic acc;
  logic cap_lo;
  logic cap_hi;
  logic push_v;
  logic [REG_W-1:0] push_d;

  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0][REG_W-1:0] d_q;

  logic               done_q;
  logic [REG_W-1:0]   ldst_q;
  logic [2*IMM_W-1:0] limm_q;

  assign acc = in_valid & ~stall & ~flush;

  // Pair tracker next state and the entry pushed into stage 0.
  always_comb begin
    st_d   = st_q;
    cap_lo = 1'b0;
    cap_hi = 1'b0;
    push_v = 1'b0;
    push_d = '0;
    if (flush) begin
      st_d = IDLE;
    end else if (acc) begin
      unique case (st_q)
        IDLE: begin
          push_d = in_dst;
          if (in_lddw) begin
            st_d   = WAIT_HI;
            cap_lo = 1'b1;
          end else begin
            push_v = 1'b1;
          end
        end
        WAIT_HI: begin
          st_d   = IDLE;
          cap_hi = 1'b1;
          push_v = 1'b1;
          push_d = ldst_q;
        end
        default: ;
      endcase
    end
  end

  // Pair tracker state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // Delay line: clear on flush, hold on stall, otherwise shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      d_q <= '0;
    end else if (flush) begin
      v_q <= '0;
      d_q <= '0;
    end else if (!stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        v_q[k] <= v_q[k-1];
        d_q[k] <= d_q[k-1];
      end
      v_q[0] <= push_v;
      d_q[0] <= push_d;
    end
  end

  // Captured lddw dst/imm halves and the one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      ldst_q <= '0;
      limm_q <= '0;
    end else begin
      done_q <= cap_hi;
      if (cap_lo) begin
        ldst_q            <= in_dst;
        limm_q[IMM_W-1:0] <= in_imm;
      end
      if (cap_hi) begin
        limm_q[2*IMM_W-1:IMM_W] <= in_imm;
      end
    end
  end

  // Per-stage hazard match against the source index.
  always_comb begin
    hit_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit_vec[k] = v_q[k] && (d_q[k] == src_idx);
    end
  end

  assign out_valid    = v_q[DEPTH-1];
  assign out_dst      = d_q[DEPTH-1];
  assign lddw_pending = (st_q == WAIT_HI);
  assign lddw_done    = done_q;
  assign lddw_dst     = ldst_q;
  assign lddw_imm     = limm_q;

endmodule

// File: tb/tb_dst_track_pipe.sv
// Bench for dst_track_pipe at DEPTH 1, 2 and 8 sharing one stimulus stream.
// Reference keeps a history queue of pushed entries and plain pair state.
module tb_dst_track_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_dst = '0;
  logic        in_lddw = 1'b0;
  logic [31:0] in_imm = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  src_idx = '0;

  logic [0:0]  h1;
  logic [1:0]  h2;
  logic [7:0]  h8;
  logic        ov1, ov2, ov8;
  logic [3:0]  od1, od2, od8;
  logic        pe1, pe2, pe8;
  logic        dn1, dn2, dn8;
  logic [3:0]  ld1, ld2, ld8;
  logic [63:0] li1, li2, li8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dst_track_pipe #(.REG_W(4), .DEPTH(1), .IMM_W(32)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dst(in_dst),
    .in_lddw(in_lddw), .in_imm(in_imm), .stall(stall), .flush(flush),
    .src_idx(src_idx), .hit_vec(h1), .out_valid(ov1), .out_dst(od1),
    .lddw_pending(pe1), .lddw_done(dn1), .lddw_dst(ld1), .lddw_imm(li1)
  );

  dst_track_pipe #(.REG_W(4), .DEPTH(2), .IMM_W(32)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dst(in_dst),
    .in_lddw(in_lddw), .in_imm(in_imm), .stall(stall), .flush(flush),
    .src_idx(src_idx), .hit_vec(h2), .out_valid(ov2), .out_dst(od2),
    .lddw_pending(pe2), .lddw_done(dn2), .lddw_dst(ld2), .lddw_imm(li2)
  );

  dst_track_pipe #(.REG_W(4), .DEPTH(8), .IMM_W(32)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dst(in_dst),
    .in_lddw(in_lddw), .in_imm(in_imm), .stall(stall), .flush(flush),
    .src_idx(src_idx), .hit_vec(h8), .out_valid(ov8), .out_dst(od8),
    .lddw_pending(pe8), .lddw_done(dn8), .lddw_dst(ld8), .lddw_imm(li8)
  );

  typedef struct packed {
    logic       v;
    logic [3:0] d;
  } ent_t;

  ent_t        hist[$];
  logic        m_pend;
  logic        m_done;
  logic [3:0]  m_ldst;
  logic [63:0] m_limm;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ent_t stage(input int k);
    if (k < hist.size()) return hist[k];
    return '0;
  endfunction

  function automatic logic [63:0] exp_hit(input int dep);
    logic [63:0] h;
    ent_t e;
    h = '0;
    for (int k = 0; k < dep; k++) begin
      e = stage(k);
      h[k] = e.v && (e.d == src_idx);
    end
    return h;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_pend = 1'b0;
    m_done = 1'b0;
    m_ldst = '0;
    m_limm = '0;
  endtask

  task automatic check_all();
    ent_t e1, e2, e8;
    e1 = stage(0);
    e2 = stage(1);
    e8 = stage(7);
    check("hit1", {63'd0, h1}, exp_hit(1));
    check("hit2", {62'd0, h2}, exp_hit(2));
    check("hit8", {56'd0, h8}, exp_hit(8));
    check("ov1", ov1, e1.v);
    check("ov2", ov2, e2.v);
    check("ov8", ov8, e8.v);
    check("od1", od1, e1.d);
    check("od2", od2, e2.d);
    check("od8", od8, e8.d);
    check("pend", {pe8, pe2, pe1}, {3{m_pend}});
    check("done", {dn8, dn2, dn1}, {3{m_done}});
    check("ldst1", ld1, m_ldst);
    check("ldst8", ld8, m_ldst);
    check("limm1", li1, m_limm);
    check("limm8", li8, m_limm);
  endtask

  // Advances the reference across the coming rising edge.
  task automatic model_edge();
    ent_t e;
    logic acc;
    logic dn;
    acc = in_valid && !stall && !flush;
    dn  = 1'b0;
    if (flush) begin
      hist.delete();
      m_pend = 1'b0;
    end else if (!stall) begin
      e = '0;
      if (acc) begin
        if (m_pend) begin
          e = '{v: 1'b1, d: m_ldst};
          m_limm[63:32] = in_imm;
          m_pend = 1'b0;
          dn = 1'b1;
        end else if (in_lddw) begin
          e = '{v: 1'b0, d: in_dst};
          m_ldst = in_dst;
          m_limm[31:0] = in_imm;
          m_pend = 1'b1;
        end else begin
          e = '{v: 1'b1, d: in_dst};
        end
      end
      hist.push_front(e);
      if (hist.size() > 8) void'(hist.pop_back());
    end
    m_done = dn;
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic l,
                      input logic [31:0] imm, input logic s, input logic f,
                      input logic [3:0] src);
    @(negedge clk);
    in_valid = v;
    in_dst   = d;
    in_lddw  = l;
    in_imm   = imm;
    stall    = s;
    flush    = f;
    src_idx  = src;
    #1;
    check_all();
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 0, 32'd0, 0, 0, 4'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_ov2", ov2, 1'b0);
    check("rst_hit8", h8, 8'd0);
    check("rst_limm", li2, 64'd0);
    check("rst_pend", pe2, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step(1, 4'd3, 0, 32'd0, 0, 0, 4'd0);
    step(1, 4'd5, 0, 32'd0, 0, 0, 4'd3);
    step(1, 4'd7, 0, 32'd0, 0, 0, 4'd3);
    check("seq_od2_3", od2, 4'd3);
    idle(4);

    step(1, 4'd9, 0, 32'd0, 0, 0, 4'd0);
    step(0, 4'd0, 0, 32'd0, 1, 0, 4'd9);
    check("stall_hit2", h2, 2'b01);
    step(0, 4'd0, 0, 32'd0, 1, 0, 4'd9);
    step(0, 4'd0, 0, 32'd0, 1, 0, 4'd9);
    idle(3);

    step(1, 4'd4, 1, 32'h11223344, 0, 0, 4'd4);
    idle(2);
    step(1, 4'd0, 0, 32'hAABBCCDD, 0, 0, 4'd4);
    step(0, 4'd0, 0, 32'd0, 0, 0, 4'd4);
    check("pair_done", dn2, 1'b1);
    check("pair_dst", ld2, 4'd4);
    check("pair_imm", li2, 64'hAABBCCDD11223344);
    check("pair_hit2", h2, 2'b01);
    idle(3);

    step(1, 4'd6, 1, 32'h1, 0, 0, 4'd0);
    step(0, 4'd0, 0, 32'd0, 0, 1, 4'd0);
    step(1, 4'd2, 0, 32'd0, 0, 0, 4'd2);
    idle(3);

    step(1, 4'd1, 0, 32'd0, 0, 0, 4'd1);
    step(1, 4'd2, 0, 32'd0, 0, 0, 4'd1);
    step(0, 4'd0, 0, 32'd0, 1, 1, 4'd1);
    step(1, 4'd8, 1, 32'h10, 0, 0, 4'd0);
    step(1, 4'd0, 0, 32'h20, 0, 0, 4'd0);
    step(1, 4'd9, 1, 32'h30, 0, 0, 4'd0);
    step(1, 4'd0, 0, 32'h40, 0, 0, 4'd9);
    step(0, 4'd0, 0, 32'd0, 0, 0, 4'd9);
    check("b2b_imm", li2, 64'h0000004000000030);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7,
           4'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 3,
           $urandom,
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 19) == 0,
           4'($urandom_range(0, 15)));
    end

    step(1, 4'd5, 0, 32'd0, 0, 0, 4'd0);
    step(1, 4'd11, 1, 32'hDEAD, 0, 0, 4'd0);
    step(0, 4'd0, 0, 32'd0, 0, 0, 4'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pend", {pe8, pe2, pe1}, 3'b000);
    check("arst_ov", {ov8, ov2, ov1}, 3'b000);
    check("arst_ldst", ld2, 4'd0);
    check("arst_limm", li8, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    step(1, 4'd12, 0, 32'd0, 0, 0, 4'd12);
    idle(9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
